// File: rtl/com_pkg.sv
// Shared register-map constants and types.
// Used by com_reg_ctrl and mojo_com.
package com_pkg;

  localparam int ADDR_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  function automatic int tmo_w(input int t);
    return $clog2(t + 1);
  endfunction

  function automatic int next_idx(
    input int i,
    input int n
  );
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/com_reg_ctrl_rr_arbiter.sv
// Round-robin grant: lowest index at or after ptr wins.
// Purely combinational, one-hot or zero output.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  int   idx;
  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/com_reg_ctrl.sv
// Register-map controller: config snapshot, writer
// arbitration, staging and read-safe commit to tx_arr.
module com_reg_ctrl
  import com_pkg::*;
#(
  parameter int ADDR_SPACE    = 256,
  parameter int NUM_REQ       = 4,
  parameter int BURST_TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*ADDR_SPACE-1:0] rx_arr,
  input  logic                    new_rx,
  input  logic                    tx_busy,
  output logic [8*ADDR_SPACE-1:0] tx_arr,
  output logic [8*ADDR_SPACE-1:0] cfg_arr,
  output logic                    cfg_update,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0]      req_last,
  input  logic [8*NUM_REQ-1:0]    req_addr,
  input  logic [8*NUM_REQ-1:0]    req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    wr_err
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int TW = tmo_w(BURST_TIMEOUT);
  localparam int AB = 8 * ADDR_SPACE;

  arb_state_t        state_q, state_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic [AB-1:0]     stg_q, stg_d;
  logic [AB-1:0]     tx_q, tx_d;
  logic [AB-1:0]     cfg_q, cfg_d;
  logic              dirty_q, dirty_d;
  logic              cfg_upd_q, cfg_upd_d;
  logic              wr_err_q, wr_err_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [PW-1:0]      sel;
  logic [ADDR_W-1:0]  b_addr;
  logic [7:0]         b_data;
  logic               b_last;
  logic               accept;
  logic               in_range;

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_arb (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (arb_gnt)
  );

  always_comb begin
    req_ready = '0;
    sel       = '0;
    if (state_q == IDLE) begin
      req_ready = arb_gnt;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (arb_gnt[i]) sel = PW'(i);
      end
    end else begin
      sel = owner_q;
      req_ready[owner_q] = req_valid[owner_q];
    end
  end

  assign accept   = |(req_valid & req_ready);
  assign b_addr   = req_addr[8*int'(sel) +: 8];
  assign b_data   = req_data[8*int'(sel) +: 8];
  assign b_last   = req_last[sel];
  assign in_range = int'(b_addr) < ADDR_SPACE;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    stg_d     = stg_q;
    tx_d      = tx_q;
    cfg_d     = cfg_q;
    dirty_d   = dirty_q;
    cfg_upd_d = 1'b0;
    wr_err_d  = 1'b0;

    if (new_rx) begin
      cfg_d     = rx_arr;
      cfg_upd_d = 1'b1;
    end

    // Commit reads stg_q, so a same-cycle beat lands next time.
    if (dirty_q && !tx_busy && state_q == IDLE) begin
      tx_d    = stg_q;
      dirty_d = 1'b0;
    end

    if (accept) begin
      if (in_range) begin
        stg_d[8*int'(b_addr) +: 8] = b_data;
        dirty_d = 1'b1;
      end else begin
        wr_err_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (b_last) begin
            ptr_d = PW'(next_idx(int'(sel), NUM_REQ));
          end else begin
            state_d = BURST;
            owner_d = sel;
            cnt_d   = '0;
          end
        end
      end
      BURST: begin
        if (accept) begin
          cnt_d = '0;
          if (b_last) begin
            state_d = IDLE;
            ptr_d   = PW'(next_idx(int'(owner_q), NUM_REQ));
          end
        end else if (cnt_q == TW'(BURST_TIMEOUT - 1)) begin
          state_d  = IDLE;
          ptr_d    = PW'(next_idx(int'(owner_q), NUM_REQ));
          cnt_d    = '0;
          wr_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      stg_q     <= '0;
      tx_q      <= '0;
      cfg_q     <= '0;
      dirty_q   <= 1'b0;
      cfg_upd_q <= 1'b0;
      wr_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      stg_q     <= stg_d;
      tx_q      <= tx_d;
      cfg_q     <= cfg_d;
      dirty_q   <= dirty_d;
      cfg_upd_q <= cfg_upd_d;
      wr_err_q  <= wr_err_d;
    end
  end

  assign tx_arr     = tx_q;
  assign cfg_arr    = cfg_q;
  assign cfg_update = cfg_upd_q;
  assign wr_err     = wr_err_q;

endmodule

// File: tb/tb_com_reg_ctrl.sv
// Directed bench for com_reg_ctrl (256-byte and
// 16-byte instances sharing the writer stimulus).
module tb_com_reg_ctrl;
  import com_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic [2047:0] rx;
  logic          new_rx;
  logic          tx_busy;
  logic [2047:0] tx_arr, cfg_arr;
  logic          cfg_update;
  logic [3:0]    req_valid, req_last, req_ready;
  logic [31:0]   req_addr, req_data;
  logic          wr_err;

  logic [127:0]  tx16, cfg16;
  logic          cfg_upd16, wr_err16;
  logic [3:0]    ready16;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  com_reg_ctrl #(
    .ADDR_SPACE(256), .NUM_REQ(4), .BURST_TIMEOUT(64)
  ) dut (
    .clk(clk), .rst(rst), .rx_arr(rx),
    .new_rx(new_rx), .tx_busy(tx_busy),
    .tx_arr(tx_arr), .cfg_arr(cfg_arr),
    .cfg_update(cfg_update),
    .req_valid(req_valid), .req_last(req_last),
    .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .wr_err(wr_err)
  );

  com_reg_ctrl #(
    .ADDR_SPACE(16), .NUM_REQ(4), .BURST_TIMEOUT(64)
  ) dut16 (
    .clk(clk), .rst(rst), .rx_arr(rx[127:0]),
    .new_rx(new_rx), .tx_busy(tx_busy),
    .tx_arr(tx16), .cfg_arr(cfg16),
    .cfg_update(cfg_upd16),
    .req_valid(req_valid), .req_last(req_last),
    .req_addr(req_addr), .req_data(req_data),
    .req_ready(ready16), .wr_err(wr_err16)
  );

  typedef struct {
    logic [3:0] valid;
    logic [3:0] ready;
    logic [1:0] ptr;
  } vec_t;

  vec_t          tbl[13];
  logic [2047:0] rx_old;
  logic [7:0]    pat;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [7:0] txb(input int a);
    return tx_arr[8*a +: 8];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input int         r,
    input logic [7:0] a,
    input logic [7:0] d,
    input logic       l
  );
    req_valid       = 4'b0;
    req_valid[r]    = 1'b1;
    req_last[r]     = l;
    req_addr[8*r +: 8] = a;
    req_data[8*r +: 8] = d;
  endtask

  initial begin
    tbl[0]  = '{4'b1000, 4'b1000, 2'd0};
    tbl[1]  = '{4'b1111, 4'b0001, 2'd1};
    tbl[2]  = '{4'b1111, 4'b0010, 2'd2};
    tbl[3]  = '{4'b1111, 4'b0100, 2'd3};
    tbl[4]  = '{4'b1111, 4'b1000, 2'd0};
    tbl[5]  = '{4'b1111, 4'b0001, 2'd1};
    tbl[6]  = '{4'b0001, 4'b0001, 2'd1};
    tbl[7]  = '{4'b1001, 4'b1000, 2'd0};
    tbl[8]  = '{4'b0000, 4'b0000, 2'd0};
    tbl[9]  = '{4'b0110, 4'b0010, 2'd2};
    tbl[10] = '{4'b0010, 4'b0010, 2'd2};
    tbl[11] = '{4'b0101, 4'b0100, 2'd3};
    tbl[12] = '{4'b0000, 4'b0000, 2'd3};

    rst = 1'b1; rx = '0; new_rx = 1'b0;
    tx_busy = 1'b0; req_valid = '0;
    req_last = '0; req_addr = '0; req_data = '0;
    tick(); tick();

    chk("rst_tx", 32'(|tx_arr), 0);
    chk("rst_cfg", 32'(|cfg_arr), 0);
    chk("rst_cfg_upd", 32'(cfg_update), 0);
    chk("rst_wr_err", 32'(wr_err), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_ptr", 32'(dut.ptr_q), 0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));

    @(negedge clk);
    rst = 1'b0;
    drive(0, 8'h10, 8'hAA, 1'b1);
    #1;
    chk("single_ready", 32'(req_ready), 32'b0001);
    tick();
    chk("single_pre", 32'(txb(16)), 0);
    @(negedge clk);
    req_valid = '0;
    tick();
    chk("single_vis", 32'(txb(16)), 32'hAA);

    for (int i = 0; i < 4; i++) begin
      req_addr[8*i +: 8] = 8'h40 + 8'(i);
      req_data[8*i +: 8] = 8'h50 + 8'(i);
    end
    req_last = 4'b1111;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      req_valid = tbl[i].valid;
      #1;
      chk($sformatf("arb_ready[%0d]", i),
          32'(req_ready), 32'(tbl[i].ready));
      tick();
      chk($sformatf("arb_ptr[%0d]", i),
          32'(dut.ptr_q), 32'(tbl[i].ptr));
    end
    chk("arb_commit", 32'(txb(8'h42)), 32'h52);

    pat = 8'b1101;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(1, 8'h20 + 8'(k), 8'(k + 1), k == 3);
      tx_busy = pat[k];
      tick();
      chk($sformatf("burst_hold[%0d]", k),
          tx_arr[8*32 +: 32], 0);
    end
    @(negedge clk);
    req_valid = '0; tx_busy = 1'b1;
    tick();
    chk("burst_busy", tx_arr[8*32 +: 32], 0);
    @(negedge clk);
    tx_busy = 1'b0;
    tick();
    chk("burst_commit", tx_arr[8*32 +: 32],
        32'h04030201);

    @(negedge clk);
    drive(2, 8'h30, 8'h33, 1'b0);
    tick();
    chk("tmo_state0", 32'(dut.state_q), 32'(BURST));
    @(negedge clk);
    drive(3, 8'h31, 8'h44, 1'b1);
    for (int i = 1; i <= 64; i++) begin
      if (i == 2) chk("tmo_wait_ready",
                      32'(req_ready), 0);
      tick();
      if (i == 63) begin
        chk("tmo_63_state", 32'(dut.state_q),
            32'(BURST));
        chk("tmo_63_err", 32'(wr_err), 0);
      end
    end
    chk("tmo_err", 32'(wr_err), 1);
    chk("tmo_state", 32'(dut.state_q), 32'(IDLE));
    chk("tmo_ready3", 32'(req_ready), 32'b1000);
    tick();
    chk("tmo_err_pulse", 32'(wr_err), 0);
    chk("tmo_ptr", 32'(dut.ptr_q), 0);
    @(negedge clk);
    req_valid = '0;
    tick();
    chk("tmo_kept", 32'(txb(8'h30)), 32'h33);
    chk("tmo_req3", 32'(txb(8'h31)), 32'h44);

    @(negedge clk);
    tx_busy = 1'b1;
    drive(0, 8'h05, 8'h55, 1'b1);
    tick();
    @(negedge clk);
    drive(0, 8'h20, 8'h99, 1'b1);
    #1;
    chk("oor_ready", 32'(ready16), 32'b0001);
    tick();
    chk("oor_err", 32'(wr_err16), 1);
    chk("oor_err256", 32'(wr_err), 0);
    chk("oor_tx", 32'(|tx16), 0);
    chk("oor_dirty", 32'(dut16.dirty_q), 1);
    @(negedge clk);
    req_valid = '0; tx_busy = 1'b0;
    tick();
    chk("oor_commit", 32'(tx16[8*5 +: 8]), 32'h55);
    chk("oor_err_pulse", 32'(wr_err16), 0);

    @(negedge clk);
    rx = {64{32'hDEADBEEF}};
    tick();
    chk("snap_hold", 32'(|cfg_arr), 0);
    chk("snap_noupd", 32'(cfg_update), 0);
    @(negedge clk);
    new_rx = 1'b1;
    rx_old = rx;
    tick();
    chk("snap_take", 32'(cfg_arr === rx_old), 1);
    chk("snap_upd", 32'(cfg_update), 1);
    @(negedge clk);
    new_rx = 1'b0;
    rx = {64{32'h12345678}};
    tick();
    chk("snap_upd_pulse", 32'(cfg_update), 0);
    chk("snap_keep", 32'(cfg_arr === rx_old), 1);

    @(negedge clk);
    drive(1, 8'h21, 8'h77, 1'b0);
    tick();
    chk("rst_burst_pre", 32'(dut.state_q),
        32'(BURST));
    @(negedge clk);
    rst = 1'b1; req_valid = '0;
    tick();
    chk("rstb_state", 32'(dut.state_q), 32'(IDLE));
    chk("rstb_ptr", 32'(dut.ptr_q), 0);
    chk("rstb_tx", 32'(|tx_arr), 0);
    chk("rstb_cfg", 32'(|cfg_arr), 0);
    chk("rstb_dirty", 32'(dut.dirty_q), 0);
    chk("rstb_ready", 32'(req_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("rstb_after", 32'(|tx_arr), 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/com_reg_ctrl.md
# com_reg_ctrl

Register-map controller between `mojo_com` and the fabric. It gives fabric blocks atomic snapshots of host-written bytes (`cfg_arr`). It arbitrates up to NUM_REQ internal writers into a staging copy of the host-readable space. It commits that staging copy to `mojo_com`'s `tx_arr` only while no host read is in flight, so a host read never sees a half-updated multi-byte value.

## Interface
- ADDR_SPACE, 256: bytes in each register array; 1..256.
- NUM_REQ, 4: internal writer count; 2..8.
- BURST_TIMEOUT, 64: idle cycles allowed inside a locked burst before it is aborted; ≥2.

- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rx_arr  in  8*ADDR_SPACE  host-written bytes from `mojo_com`.
- new_rx  in  1  one-cycle pulse from `mojo_com` marking the end of a host write.
- tx_busy  in  1  `mojo_com` host-read-in-progress flag.
- tx_arr  out  8*ADDR_SPACE  committed bytes to `mojo_com`.
- cfg_arr  out  8*ADDR_SPACE  atomic snapshot of `rx_arr`.
- cfg_update  out  1  one-cycle pulse; `cfg_arr` changed this cycle.
- req_valid  in  NUM_REQ  per-requester write request.
- req_last  in  NUM_REQ  the beat ends the requester's burst.
- req_addr  in  8*NUM_REQ  byte address; slice i belongs to requester i.
- req_data  in  8*NUM_REQ  byte data.
- req_ready  out  NUM_REQ  grant. Beat is accepted at a posedge with valid & ready.
- wr_err  out  1  one-cycle pulse on a dropped beat (address ≥ ADDR_SPACE) or on a burst timeout.

## Operation
- Reset values: `tx_arr`, `cfg_arr` and the staging array are 0. `cfg_update`, `wr_err` and `req_ready` are 0. The round-robin pointer is 0. The state is IDLE and `dirty` is 0.
- Config snapshot: when `new_rx`=1, `cfg_arr` ← `rx_arr` and `cfg_update`=1 in the following cycle. `cfg_arr` never changes otherwise.
- Arbiter FSM:
  - IDLE: grant the lowest index at or after the pointer with `req_valid`=1. At most one `req_ready` is asserted, and it is a combinational function of `req_valid` and the pointer.
    - An accepted beat with `req_last`=1 stays in IDLE and sets pointer = owner+1 (mod NUM_REQ).
    - An accepted beat with `req_last`=0 goes to BURST with owner latched.
  - BURST: only the owner can be granted, whenever its `req_valid`=1.
    - A beat with `req_last`=1 goes to IDLE, sets pointer = owner+1 and clears the idle counter.
    - The idle counter increments each cycle the owner's `req_valid`=0 and clears on an accepted beat.
    - When the counter reaches BURST_TIMEOUT: go to IDLE, pointer = owner+1, `wr_err` pulse. Beats already written stay in staging.
- Write path: an accepted beat with addr < ADDR_SPACE sets `staging[addr]` ← data and `dirty` ← 1. If addr ≥ ADDR_SPACE the beat is still accepted, nothing is written, and `wr_err` pulses the next cycle.
- Commit: when `dirty`=1, `tx_busy`=0 and the state is IDLE, then `tx_arr` ← staging and `dirty` ← 0 at the edge.
  - If a beat is accepted in the same cycle, `tx_arr` takes the pre-write staging and `dirty` stays 1.
  - `tx_arr` never changes in a cycle where `tx_busy`=1 was sampled, and never mid-burst.

## Timing
- Write-to-visible latency with `tx_busy`=0, single beat: accepted at edge N, staging updated at N, commit at N+1, `tx_arr` valid after N+1.
- `new_rx` at edge N puts `cfg_arr` and `cfg_update` valid in cycle N+1.
- Commit is blocked while `tx_busy`=1. The first commit opportunity is the first edge with `tx_busy`=0 sampled.
- `mojo_com` raises `tx_busy` one cycle before its first byte read. A commit at that same edge is therefore safe.
- A reset asserted mid-burst or mid-commit restores the reset values at the next edge. Partial bursts are discarded.

## Structure
- Shared constants (ADDR_W=8, arbiter state encoding IDLE/BURST, timeout counter width `$clog2(BURST_TIMEOUT+1)`) go in the team's `com` package/header, which is also used by `mojo_com`.
- One sub-module: `rr_arbiter`, a parameterised NUM_REQ round-robin grant with pointer input and one-hot grant output. FSM, staging, commit and snapshot logic stay in `com_reg_ctrl`.

## Test plan
- Single writes: req0 writes 0x10←0xAA with `tx_busy`=0 → `req_ready`[0]=1 same cycle; `tx_arr`[0x10]=0xAA two edges after acceptance.
- Atomic burst under read: req1 bursts 0x20..0x23 ← 01,02,03,04 (last on the 4th beat) while `tx_busy` toggles → `tx_arr` bytes 0x20..0x23 are never a mix of old and new; they commit on the first `tx_busy`=0 edge after the last beat.
- Fairness: all four requesters hold `req_valid` with `req_last`=1 → grants cycle 0,1,2,3,0; no requester waits more than 3 grants.
- Timeout: req2 starts a burst with `req_last`=0, then drops valid for 64 cycles → `wr_err` pulse, state IDLE; req3's pending request is granted next cycle.
- Out of range with ADDR_SPACE=16: write to addr 0x20 → accepted, `wr_err` pulse, `tx_arr` unchanged, `dirty` unchanged.
- Snapshot and reset: `rx_arr` changes without `new_rx` → `cfg_arr` holds. `new_rx` pulse → `cfg_arr`=`rx_arr` and `cfg_update`=1 next cycle. `rst` mid-burst → all outputs 0 and pointer 0.
